// File: rtl/alu_div_seq_pkg.sv
// Shared definitions for the sequential divider and the alu it drives.
package alu_div_seq_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int CNT_W      = 5;

  localparam logic [DATA_WIDTH-1:0] ONE = 1;

  // alu operation encodings
  localparam logic [2:0] ALUop_AND = 3'b000;
  localparam logic [2:0] ALUop_OR  = 3'b001;
  localparam logic [2:0] ALUop_ADD = 3'b010;
  localparam logic [2:0] ALUop_SUB = 3'b110;
  localparam logic [2:0] ALUop_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

  // Unsigned magnitude of an operand; -2^31 maps to 0x80000000.
  function automatic logic [DATA_WIDTH-1:0] magnitude(input logic [DATA_WIDTH-1:0] x,
                                                      input logic                  sgn);
    return (sgn && x[DATA_WIDTH-1]) ? (~x + ONE) : x;
  endfunction

endpackage

// File: rtl/alu_div_seq_alu.sv
// Shared 32-bit alu. For SUB, CarryOut reports a borrow (A < B unsigned).
module alu
  import alu_div_seq_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [2:0]            ALUop,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);

  logic [DATA_WIDTH:0] add_ext;
  logic [DATA_WIDTH:0] sub_ext;
  logic                add_ovf;
  logic                sub_ovf;

  assign add_ext = {1'b0, A} + {1'b0, B};
  assign sub_ext = {1'b0, A} + {1'b0, ~B} + {1'b0, ONE};
  assign add_ovf = (A[DATA_WIDTH-1] == B[DATA_WIDTH-1]) &&
                   (add_ext[DATA_WIDTH-1] != A[DATA_WIDTH-1]);
  assign sub_ovf = (A[DATA_WIDTH-1] != B[DATA_WIDTH-1]) &&
                   (sub_ext[DATA_WIDTH-1] != A[DATA_WIDTH-1]);

  // Operation select; carry and overflow only meaningful for ADD/SUB.
  always_comb begin
    Result   = '0;
    CarryOut = 1'b0;
    Overflow = 1'b0;
    case (ALUop)
      ALUop_AND: Result = A & B;
      ALUop_OR:  Result = A | B;
      ALUop_ADD: begin
        Result   = add_ext[DATA_WIDTH-1:0];
        CarryOut = add_ext[DATA_WIDTH];
        Overflow = add_ovf;
      end
      ALUop_SUB: begin
        Result   = sub_ext[DATA_WIDTH-1:0];
        CarryOut = ~sub_ext[DATA_WIDTH];
        Overflow = sub_ovf;
      end
      ALUop_SLT: Result = {{(DATA_WIDTH-1){1'b0}}, sub_ext[DATA_WIDTH-1] ^ sub_ovf};
      default:   Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/alu_div_seq.sv
// Iterative restoring divider, one quotient bit per cycle through the shared alu.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// CALC  | 32 restoring-division steps
// FIX   | apply result signs, publish quotient/remainder
// DONE  | result held until the consumer takes it
module alu_div_seq #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  is_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  div_by_zero
);

  import alu_div_seq_pkg::*;

  div_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic [DATA_WIDTH-1:0] q_reg;
  logic [DATA_WIDTH-1:0] r_reg;
  logic [DATA_WIDTH-1:0] dvs_mag;
  logic                  neg_q;
  logic                  neg_r;

  logic                  accept;
  logic                  r_msb;
  logic                  take;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] alu_a;
  logic [DATA_WIDTH-1:0] alu_b;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_borrow;
  logic                  alu_ovf;
  logic                  alu_zero;
  logic                  alu_unused;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready;

  // r_msb is the bit shifted out of R; when set the partial remainder is
  // at least 2^32 and the subtraction must succeed regardless of borrow.
  assign r_msb   = r_reg[DATA_WIDTH-1];
  assign r_shift = {r_reg[DATA_WIDTH-2:0], q_reg[DATA_WIDTH-1]};
  assign take    = r_msb | ~alu_borrow;

  // alu computes the trial subtraction in CALC and 0 - Q in FIX.
  always_comb begin
    alu_a = r_shift;
    alu_b = dvs_mag;
    if (state == FIX) begin
      alu_a = '0;
      alu_b = q_reg;
    end
  end

  alu u_alu (
    .A        (alu_a),
    .B        (alu_b),
    .ALUop    (ALUop_SUB),
    .Result   (alu_result),
    .Overflow (alu_ovf),
    .CarryOut (alu_borrow),
    .Zero     (alu_zero)
  );

  assign alu_unused = alu_ovf ^ alu_zero;

  // Control FSM with registered results; remainder negation uses a local subtractor
  // so FIX completes in one cycle while the alu negates the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            neg_q   <= is_signed & (dividend[DATA_WIDTH-1] ^ divisor[DATA_WIDTH-1]);
            neg_r   <= is_signed & dividend[DATA_WIDTH-1];
            q_reg   <= magnitude(dividend, is_signed);
            r_reg   <= '0;
            dvs_mag <= magnitude(divisor, is_signed);
            cnt     <= '0;
            if (divisor == '0) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
              out_valid   <= 1'b1;
              state       <= DONE;
            end else begin
              div_by_zero <= 1'b0;
              state       <= CALC;
            end
          end
        end
        CALC: begin
          q_reg <= {q_reg[DATA_WIDTH-2:0], take};
          r_reg <= take ? alu_result : r_shift;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          quotient    <= neg_q ? alu_result : q_reg;
          remainder   <= neg_r ? ('0 - r_reg) : r_reg;
          div_by_zero <= 1'b0;
          out_valid   <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_div_seq.sv
// Directed bench for the sequential divider.
module tb_alu_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_signed;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_div_seq #(.DATA_WIDTH(32), .CNT_W(5)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .is_signed   (is_signed),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Present one request, then count edges after the accepting edge until out_valid.
  // Operands are scrambled right after accept; the result must not notice.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output int lat);
    @(negedge clk);
    dividend  = a;
    divisor   = b;
    is_signed = s;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    dividend  = 32'hDEADBEEF;
    divisor   = 32'h0;
    is_signed = ~s;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; is_signed = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat;
    run_op(32'd100, 32'd7, 1'b0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL u100_7_latency: got %0d want 33", lat); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL u100_7_q: got %h want %h", quotient, 32'd14); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL u100_7_r: got %h want %h", remainder, 32'd2); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL u100_7_dbz: got %b want 0", div_by_zero); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL u100_7_in_ready_done: got %b want 0", in_ready); end
    release_result();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL u100_7_valid_drop: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL u100_7_in_ready_after: got %b want 1", in_ready); end
  endtask

  task automatic test_signed();
    int lat;
    run_op(32'hFFFFFFF9, 32'h2, 1'b1, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL s_m7_2_latency: got %0d want 33", lat); end
    checks++; if (quotient !== 32'hFFFFFFFD) begin errors++; $display("FAIL s_m7_2_q: got %h want fffffffd", quotient); end
    checks++; if (remainder !== 32'hFFFFFFFF) begin errors++; $display("FAIL s_m7_2_r: got %h want ffffffff", remainder); end
    release_result();
  endtask

  task automatic test_r_msb();
    int lat;
    run_op(32'hFFFFFFFF, 32'h1, 1'b0, lat);
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL uffff_1_q: got %h want ffffffff", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL uffff_1_r: got %h want 0", remainder); end
    release_result();
    run_op(32'hFFFFFFFF, 32'h80000000, 1'b0, lat);
    checks++; if (quotient !== 32'h1) begin errors++; $display("FAIL uffff_8000_q: got %h want 1", quotient); end
    checks++; if (remainder !== 32'h7FFFFFFF) begin errors++; $display("FAIL uffff_8000_r: got %h want 7fffffff", remainder); end
    release_result();
  endtask

  // Zero divisor is resolved by the accepting edge itself, no iteration.
  task automatic test_div_zero();
    int lat;
    run_op(32'd5, 32'd0, 1'b0, lat);
    checks++; if (lat != 0) begin errors++; $display("FAIL dz5_latency: got %0d want 0 edges past accept", lat); end
    checks++; if (quotient !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz5_q: got %h want ffffffff", quotient); end
    checks++; if (remainder !== 32'd5) begin errors++; $display("FAIL dz5_r: got %h want 5", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz5_dbz: got %b want 1", div_by_zero); end
    release_result();
    run_op(32'hFFFFFFF7, 32'd0, 1'b1, lat);
    checks++; if (remainder !== 32'hFFFFFFF7) begin errors++; $display("FAIL dz_neg_r: got %h want fffffff7", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_neg_dbz: got %b want 1", div_by_zero); end
    release_result();
  endtask

  task automatic test_signed_overflow();
    int lat;
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1, lat);
    checks++; if (quotient !== 32'h80000000) begin errors++; $display("FAIL sovf_q: got %h want 80000000", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL sovf_r: got %h want 0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL sovf_dbz: got %b want 0", div_by_zero); end
    release_result();
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(32'hFFFFFFEC, 32'd3, 1'b1, lat);
    checks++; if (quotient !== 32'hFFFFFFFA) begin errors++; $display("FAIL b2b_m20_3_q: got %h want fffffffa", quotient); end
    checks++; if (remainder !== 32'hFFFFFFFE) begin errors++; $display("FAIL b2b_m20_3_r: got %h want fffffffe", remainder); end
    release_result();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b want 1", in_ready); end
    run_op(32'd20, 32'hFFFFFFFD, 1'b1, lat);
    checks++; if (quotient !== 32'hFFFFFFFA) begin errors++; $display("FAIL b2b_20_m3_q: got %h want fffffffa", quotient); end
    checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL b2b_20_m3_r: got %h want 2", remainder); end
    release_result();
    run_op(32'hFFFFFFF9, 32'd2, 1'b0, lat);
    checks++; if (quotient !== 32'h7FFFFFFC) begin errors++; $display("FAIL b2b_ufff9_2_q: got %h want 7ffffffc", quotient); end
    checks++; if (remainder !== 32'd1) begin errors++; $display("FAIL b2b_ufff9_2_r: got %h want 1", remainder); end
    release_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'd100, 32'd7, 1'b0, lat);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; dividend = 32'd50; divisor = 32'd5; is_signed = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL bp_q[%0d]: got %h want e", i, quotient); end
      checks++; if (remainder !== 32'd2) begin errors++; $display("FAIL bp_r[%0d]: got %h want 2", i, remainder); end
      @(posedge clk);
      #1;
    end
    release_result();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_after: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_after: got %b want 0", out_valid); end
    checks++; if (quotient !== 32'd14) begin errors++; $display("FAIL bp_q_after: got %h want e", quotient); end
  endtask

  task automatic test_reset_abort();
    int lat;
    @(negedge clk);
    dividend = 32'd1000; divisor = 32'd3; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b want 1", in_ready); end
    checks++; if (quotient !== 32'h0) begin errors++; $display("FAIL abort_q: got %h want 0", quotient); end
    checks++; if (remainder !== 32'h0) begin errors++; $display("FAIL abort_r: got %h want 0", remainder); end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd9, 32'd3, 1'b0, lat);
    checks++; if (lat != 33) begin errors++; $display("FAIL abort_9_3_latency: got %0d want 33", lat); end
    checks++; if (quotient !== 32'd3) begin errors++; $display("FAIL abort_9_3_q: got %h want 3", quotient); end
    checks++; if (remainder !== 32'd0) begin errors++; $display("FAIL abort_9_3_r: got %h want 0", remainder); end
    release_result();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_r_msb();
    test_div_zero();
    test_signed_overflow();
    test_back_to_back();
    test_backpressure();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
